// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS single-cycle core.
// Holds opcode constants, ALUop encodings, instruction field positions,
// the fetch FSM state enum and a branch-offset helper.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned WAIT_W = 8;   // covers MAX_WAIT up to 255

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // ALUop encodings from the control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_BNE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  // Sign-extended word offset of a branch immediate
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection.
// Ports: pc_plus4, instr, jmp, branch, bne, alu_zero in; next_pc out.
// Priority: jump, then taken branch (BEQ/BNE via alu_zero ^ bne), then pc+4.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] instr,
  input  logic            jmp,
  input  logic            branch,
  input  logic            bne,
  input  logic            alu_zero,
  output logic [XLEN-1:0] next_pc
);

  // Opcode bits are decoded upstream; not needed here
  logic unused_opcode;
  assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (jmp) begin
      next_pc = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    end else if (branch && (alu_zero ^ bne)) begin
      next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the MIPS single-cycle core.
// Holds the PC, fetches from instruction memory over req/ready, presents the
// instruction and opcode to the decoder and advances the PC after execution.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req/imem_addr            fetch request and word address (= pc)
//   imem_rdata/imem_ready         returned instruction and handshake
//   instr/opcode/instr_valid      current instruction to the decoder
//   pc/pc_plus4                   current instruction address and pc + 4
//   jmp/branch/bne/alu_zero       next-PC controls for the current instruction
//   stall                         hold the current instruction in EXEC
//   fetch_err                     sticky instruction-memory timeout
// Optional macro FETCH_PERF_EN adds perf_retired, perf_stall, perf_taken.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  instr,
  output logic [OPC_W-1:0] opcode,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  input  logic             jmp,
  input  logic             branch,
  input  logic             bne,
  input  logic             alu_zero,
  input  logic             stall,
  output logic             fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_retired,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_taken
`endif
);

  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  fetch_state_e      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   next_pc_al;

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .jmp      (jmp),
    .branch   (branch),
    .bne      (bne),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  // Low PC bits are always forced to zero on load
  assign next_pc_al = {next_pc[31:2], 2'b00};
  assign imem_addr  = pc;

  // Fetch FSM; outputs are set on the transition into each state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC_AL;
      pc_plus4    <= XLEN'(RESET_PC_AL + 32'd4);
      instr       <= '0;
      opcode      <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            opcode      <= imem_rdata[OPCODE_MSB:OPCODE_LSB];
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end else if (wait_cnt == WAIT_LAST) begin
            // MAX_WAIT fetch cycles without ready: give up
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ST_ERROR;
          end else begin
            wait_cnt <= WAIT_W'(wait_cnt + 1'b1);
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc          <= next_pc_al;
            pc_plus4    <= XLEN'(next_pc_al + 32'd4);
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_ERROR: begin
          fetch_err   <= 1'b1;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic taken_c;
  assign taken_c = jmp | (branch & (alu_zero ^ bne));

  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
      perf_taken   <= '0;
    end else begin
      if (state == ST_EXEC && !stall) begin
        perf_retired <= 32'(perf_retired + 32'd1);
        if (taken_c) begin
          perf_taken <= 32'(perf_taken + 32'd1);
        end
      end
      if ((state == ST_FETCH && !imem_ready) || (state == ST_EXEC && stall)) begin
        perf_stall <= 32'(perf_stall + 32'd1);
      end
    end
  end
`endif

endmodule
